// File: rtl/alu_seq_if.sv
// Request/response bus between the EX-stage pipeline control and alu_seq.
//
// Handshake: a request transfers on a rising Clk edge where InValid and
// InReady are both 1; ALUControl, A and B are sampled only on that edge.
// A result transfers on an edge where OutValid and OutReady are both 1.
// OutValid, ALUResult, Hi and Zero are held steady until that edge.
// Neither side may make its valid wait on the other side's ready.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             InValid;
  logic             InReady;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] ALUResult;
  logic [WIDTH-1:0] Hi;
  logic             Zero;

  // Pipeline side: issues operations and consumes results.
  modport master (
    output InValid, ALUControl, A, B, OutReady,
    input  InReady, OutValid, ALUResult, Hi, Zero
  );

  // ALU side.
  modport slave (
    input  InValid, ALUControl, A, B, OutReady,
    output InReady, OutValid, ALUResult, Hi, Zero
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked EX-stage ALU. Single-cycle ops finish one edge after the
// request is taken. Unsigned multiply (shift-add) and unsigned divide
// (restoring) iterate one bit per cycle for WIDTH cycles. The result
// registers change only when a new result is loaded.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic       Clk,
  input  logic       Reset_n,
  alu_seq_if.slave   bus,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1011;

  state_t           state_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] a_q;    // multiplicand (mul) or divisor (divu)
  logic [WIDTH-1:0] acc_q;  // product high half (mul) or partial remainder (divu)
  logic [WIDTH-1:0] lo_q;   // multiplier/product low half (mul) or dividend/quotient (divu)
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] hi_q;
  logic             zero_q;

  logic [WIDTH-1:0] alu_d;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] step_acc_d;
  logic [WIDTH-1:0] step_lo_d;

  assign shamt = bus.B[SHW-1:0];

  // Single-cycle result, computed straight from the request operands.
  always_comb begin
    alu_d = '0;
    case (bus.ALUControl)
      4'b0000: alu_d = bus.A & bus.B;
      4'b0001: alu_d = bus.A | bus.B;
      4'b0010: alu_d = bus.A + bus.B;
      4'b0011: alu_d = bus.A ^ bus.B;
      4'b0100: alu_d = bus.A << shamt;
      4'b0101: alu_d = bus.A >> shamt;
      4'b0110: alu_d = bus.A - bus.B;
      4'b0111: alu_d = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      4'b1001: alu_d = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      4'b1010: alu_d = $unsigned($signed(bus.A) >>> shamt);
      4'b1100: alu_d = ~(bus.A | bus.B);
      default: alu_d = '0;
    endcase
  end

  // One iteration of multiply or divide; state_q selects which.
  always_comb begin
    mul_sum    = {1'b0, acc_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    div_trial  = {acc_q, lo_q[WIDTH-1]};
    div_ge     = (div_trial >= {1'b0, a_q});
    step_acc_d = mul_sum[WIDTH:1];
    step_lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
    if (state_q == DIV) begin
      // When the divisor fits, the difference is below the divisor, so
      // the low WIDTH bits of the subtraction are exact.
      step_acc_d = div_ge ? (div_trial[WIDTH-1:0] - a_q) : div_trial[WIDTH-1:0];
      step_lo_d  = {lo_q[WIDTH-2:0], div_ge};
    end
  end

  // Control FSM plus datapath and result registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.InValid) begin
            if (bus.ALUControl == OP_MUL) begin
              a_q     <= bus.A;
              lo_q    <= bus.B;
              acc_q   <= '0;
              cnt_q   <= SHW'(WIDTH - 1);
              state_q <= MUL;
            end else if (bus.ALUControl == OP_DIVU) begin
              if (bus.B == '0) begin
                // Divide by zero: no iteration, fixed result pattern.
                res_q   <= '1;
                hi_q    <= bus.A;
                zero_q  <= 1'b0;
                state_q <= DONE;
              end else begin
                a_q     <= bus.B;
                lo_q    <= bus.A;
                acc_q   <= '0;
                cnt_q   <= SHW'(WIDTH - 1);
                state_q <= DIV;
              end
            end else begin
              res_q   <= alu_d;
              hi_q    <= '0;
              zero_q  <= (alu_d == '0);
              state_q <= DONE;
            end
          end
        end
        MUL, DIV: begin
          acc_q <= step_acc_d;
          lo_q  <= step_lo_d;
          cnt_q <= cnt_q - SHW'(1);
          if (cnt_q == '0) begin
            // Last step: {acc, lo} is {Hi, ALUResult} for both operations.
            res_q   <= step_lo_d;
            hi_q    <= step_acc_d;
            zero_q  <= (step_lo_d == '0);
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.OutReady) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.InReady   = (state_q == IDLE);
  assign bus.OutValid  = (state_q == DONE);
  assign bus.ALUResult = res_q;
  assign bus.Hi        = hi_q;
  assign bus.Zero      = zero_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32 and WIDTH=8.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst32_n;
  logic       rst8_n;
  logic [1:0] st32;
  logic [1:0] st8;
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(32)) b32 ();
  alu_seq_if #(.WIDTH(8))  b8 ();

  alu_seq #(.WIDTH(32)) u_dut32 (
    .Clk     (clk),
    .Reset_n (rst32_n),
    .bus     (b32.slave),
    .state_o (st32)
  );

  alu_seq #(.WIDTH(8)) u_dut8 (
    .Clk     (clk),
    .Reset_n (rst8_n),
    .bus     (b8.slave),
    .state_o (st8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op on the 32-bit DUT, measure latency, check the result.
  task automatic run32(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_lat,
                       input logic [31:0] exp_res, input logic [31:0] exp_hi);
    int lat;
    bit busy_ok;
    bit ready_seen;
    ready_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (b32.InReady === 1'b1) begin
        ready_seen = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_ready"}, ready_seen, 1);
    b32.InValid = 1'b1; b32.ALUControl = op; b32.A = a; b32.B = b;
    tick();
    b32.InValid = 1'b0;
    b32.ALUControl = 4'($urandom_range(0, 15));
    b32.A = $urandom; b32.B = $urandom;
    lat = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      if (b32.InReady !== 1'b0) busy_ok = 1'b0;
      if (b32.OutValid === 1'b1) begin
        lat = k;
        break;
      end
      tick();
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy"}, busy_ok, 1);
    check({tag, "_res"}, b32.ALUResult, exp_res);
    check({tag, "_hi"}, b32.Hi, exp_hi);
    check({tag, "_zero"}, b32.Zero, (exp_res == 32'd0));
    if (b32.OutReady) begin
      tick();
      check({tag, "_idle"}, {b32.InReady, b32.OutValid}, 2'b10);
    end
  endtask

  // Same flow for the 8-bit DUT.
  task automatic run8(input string tag, input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b, input int exp_lat,
                      input logic [7:0] exp_res, input logic [7:0] exp_hi);
    int lat;
    for (int i = 0; i < 50; i++) begin
      if (b8.InReady === 1'b1) break;
      tick();
    end
    b8.InValid = 1'b1; b8.ALUControl = op; b8.A = a; b8.B = b;
    tick();
    b8.InValid = 1'b0;
    b8.A = 8'($urandom); b8.B = 8'($urandom);
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      if (b8.OutValid === 1'b1) begin
        lat = k;
        break;
      end
      tick();
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_res"}, b8.ALUResult, exp_res);
    check({tag, "_hi"}, b8.Hi, exp_hi);
    check({tag, "_zero"}, b8.Zero, (exp_res == 8'd0));
    tick();
  endtask

  initial begin
    bit stable_ok;
    bit no_valid;
    b32.InValid = 1'b0; b32.ALUControl = 4'd0; b32.A = '0; b32.B = '0; b32.OutReady = 1'b1;
    b8.InValid  = 1'b0; b8.ALUControl  = 4'd0; b8.A  = '0; b8.B  = '0; b8.OutReady  = 1'b1;
    rst32_n = 1'b1;
    rst8_n  = 1'b1;

    // Asynchronous reset, checked before any following clock edge.
    #8;
    rst32_n = 1'b0;
    rst8_n  = 1'b0;
    #1;
    check("rst_ready", b32.InReady, 1);
    check("rst_valid", b32.OutValid, 0);
    check("rst_res", b32.ALUResult, 0);
    check("rst_hi", b32.Hi, 0);
    check("rst_zero", b32.Zero, 1);
    check("rst_state", st32, 0);
    check("rst8_flags", {b8.InReady, b8.OutValid, b8.Zero}, 3'b101);
    repeat (2) @(posedge clk);
    #1;
    rst32_n = 1'b1;
    rst8_n  = 1'b1;

    // Single-cycle ops.
    run32("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'h1, 1, 32'h0, 32'h0);
    run32("sltu", 4'b0111, 32'hFFFFFFFE, 32'h1, 1, 32'h0, 32'h0);
    run32("slt", 4'b1001, 32'hFFFFFFFE, 32'h1, 1, 32'h1, 32'h0);
    run32("sra", 4'b1010, 32'hFFFFFFFE, 32'h21, 1, 32'hFFFFFFFF, 32'h0);
    run32("srl", 4'b0101, 32'hFFFFFFFE, 32'h21, 1, 32'h7FFFFFFF, 32'h0);
    run32("and", 4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 1, 32'h00F000F0, 32'h0);
    run32("or", 4'b0001, 32'hF0F0F0F0, 32'h0FF00FF0, 1, 32'hFFF0FFF0, 32'h0);
    run32("xor", 4'b0011, 32'hF0F0F0F0, 32'h0FF00FF0, 1, 32'hFF00FF00, 32'h0);
    run32("nor", 4'b1100, 32'hF0F0F0F0, 32'h0FF00FF0, 1, 32'h000F000F, 32'h0);
    run32("sub", 4'b0110, 32'd3, 32'd5, 1, 32'hFFFFFFFE, 32'h0);
    run32("sll", 4'b0100, 32'h1, 32'h3F, 1, 32'h80000000, 32'h0);
    run32("bad_op", 4'b1101, 32'h1, 32'h1, 1, 32'h0, 32'h0);

    // Multiply and divide.
    run32("mul_max", 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32'h00000001, 32'hFFFFFFFE);
    run32("mul_shift", 4'b1000, 32'h12345678, 32'h10, 33, 32'h23456780, 32'h1);
    run32("divu", 4'b1011, 32'd100, 32'd7, 33, 32'd14, 32'd2);
    run32("divu_big", 4'b1011, 32'hFFFFFFFF, 32'h10, 33, 32'h0FFFFFFF, 32'hF);
    run32("divu_zero", 4'b1011, 32'd5, 32'd0, 1, 32'hFFFFFFFF, 32'd5);

    // Backpressure: result held, new request refused until consumed.
    b32.OutReady = 1'b0;
    run32("bp_add", 4'b0010, 32'd2, 32'd3, 1, 32'd5, 32'd0);
    b32.InValid = 1'b1; b32.ALUControl = 4'b0110; b32.A = 32'd10; b32.B = 32'd4;
    stable_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!(b32.OutValid === 1'b1 && b32.ALUResult === 32'd5 && b32.Hi === 32'd0 &&
            b32.Zero === 1'b0 && b32.InReady === 1'b0)) stable_ok = 1'b0;
    end
    check("bp_stable", stable_ok, 1);
    b32.OutReady = 1'b1;
    tick();
    check("bp_idle", {b32.InReady, b32.OutValid}, 2'b10);
    check("bp_keep_res", b32.ALUResult, 32'd5);
    tick();
    b32.InValid = 1'b0;
    check("bp_next_valid", b32.OutValid, 1);
    check("bp_next_res", b32.ALUResult, 32'd6);
    tick();

    // Reset during a 32-bit multiply.
    b32.InValid = 1'b1; b32.ALUControl = 4'b1000; b32.A = 32'hFFFFFFFF; b32.B = 32'hFFFFFFFF;
    tick();
    b32.InValid = 1'b0;
    no_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (b32.OutValid !== 1'b0) no_valid = 1'b0;
      tick();
    end
    check("rmul_busy", b32.InReady, 0);
    rst32_n = 1'b0;
    b32.InValid = 1'b1; b32.ALUControl = 4'b0010; b32.A = 32'd7; b32.B = 32'd7;
    #1;
    check("rmul_rst_flags", {b32.InReady, b32.OutValid, b32.Zero}, 3'b101);
    check("rmul_rst_res", b32.ALUResult, 32'd0);
    tick();
    tick();
    check("rmul_rst_ignore", {b32.InReady, b32.OutValid, b32.ALUResult}, {2'b10, 32'd0});
    b32.InValid = 1'b0;
    rst32_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (b32.OutValid !== 1'b0) no_valid = 1'b0;
      tick();
    end
    check("rmul_no_valid", no_valid, 1);
    run32("rmul_add", 4'b0010, 32'd2, 32'd3, 1, 32'd5, 32'd0);

    // Same reset scenario on the 8-bit instance.
    run8("w8_add", 4'b0010, 8'hFF, 8'h01, 1, 8'h00, 8'h00);
    b8.InValid = 1'b1; b8.ALUControl = 4'b1000; b8.A = 8'hFF; b8.B = 8'hFF;
    tick();
    b8.InValid = 1'b0;
    no_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b8.OutValid !== 1'b0) no_valid = 1'b0;
      tick();
    end
    rst8_n = 1'b0;
    #1;
    check("w8_rst_flags", {b8.InReady, b8.OutValid, b8.Zero}, 3'b101);
    tick();
    rst8_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (b8.OutValid !== 1'b0) no_valid = 1'b0;
      tick();
    end
    check("w8_no_valid", no_valid, 1);
    run8("w8_mul", 4'b1000, 8'hFF, 8'hFF, 9, 8'h01, 8'hFE);
    run8("w8_divu", 4'b1011, 8'd200, 8'd9, 9, 8'd22, 8'd2);
    run8("w8_sra", 4'b1010, 8'h80, 8'h0B, 1, 8'hF0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 32-bit combinational ALU in the MIPS datapath. It executes all existing single-cycle ALU operations with a registered result. It adds signed compare, arithmetic right shift, an iterative unsigned multiply (full double-width product) and an iterative unsigned divide (quotient and remainder). It sits in the EX stage, and the pipeline control stalls on its valid/ready handshake.

## Interface
- WIDTH, 32, operand/result width; must be ≥ 4 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width; derived, do not override.
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- InValid  in  1  operation request.
- InReady  out  1  block can accept a request.
- ALUControl  in  4  operation select; sampled on accept.
- A, B  in  WIDTH  operands; sampled on accept.
- OutValid  out  1  result valid; held until consumed.
- OutReady  in  1  consumer takes the result.
- ALUResult  out  WIDTH  primary result.
- Hi  out  WIDTH  product high half (mul) or remainder (divu); 0 for all other ops.
- Zero  out  1  ALUResult == 0; registered with ALUResult.

## Operation
- Clock and reset: one clock, Clk. Reset_n is asynchronous and active-low.
- Accept condition: a request is accepted in a cycle where InValid & InReady at the Clk edge. ALUControl, A and B are captured in internal registers, so the inputs may change after accept.
- InReady = (state == IDLE). It is combinational from state.
- Single-cycle ops (ALUResult value):
  - 0000 A&B
  - 0001 A|B
  - 0010 A+B (mod 2^WIDTH)
  - 0011 A^B
  - 0100 A<<B[SHW-1:0]
  - 0101 A>>B[SHW-1:0] logical
  - 0110 A−B (mod 2^WIDTH)
  - 0111 unsigned A<B → 1, else 0
  - 1001 signed A<B → 1, else 0
  - 1010 A>>>B[SHW-1:0] arithmetic
  - 1100 ~(A|B)
  - Any unlisted code → ALUResult 0, Hi 0.
- 1000 mul: unsigned, shift-add, one partial product per cycle for WIDTH cycles. Product is {Hi, ALUResult}, 2·WIDTH bits.
- 1011 divu: unsigned restoring divide, one quotient bit per cycle for WIDTH cycles. ALUResult = quotient, Hi = remainder.
- Divide by zero (B == 0 on a divu): no iteration. ALUResult = all ones, Hi = A. The op completes with single-cycle latency.
- States:
  - IDLE: accept a request → DONE for a single-cycle op or divide-by-zero, → MUL for mul, → DIV for divu.
  - MUL / DIV: iteration counter runs WIDTH−1 down to 0. At count 0, load the outputs and go → DONE.
  - DONE: OutValid = 1. If OutReady, go → IDLE next edge; otherwise hold.
- Output stability: ALUResult, Hi and Zero update only on entry to DONE. They stay stable until the next result is loaded; they are not cleared on return to IDLE.
- No back-to-back accept: a new request cannot be accepted in the DONE cycle, because InReady is 0 there.

## Timing
- Reset values (immediately on Reset_n low, regardless of Clk): state IDLE, InReady 1, OutValid 0, ALUResult 0, Hi 0, Zero 1, counter 0.
- Reset mid-operation: an in-flight mul/div is abandoned with no output. The first request after Reset_n rises is accepted normally.
- Inputs are ignored while Reset_n is low.
- Latency, accept at edge N:
  - Single-cycle ops and divide-by-zero: OutValid high after edge N+1.
  - mul / divu: OutValid high after edge N+WIDTH+1; InReady is low for cycles N+1 … N+WIDTH+1.
- OutValid is held for as long as OutReady stays low. InReady returns high one edge after the OutValid & OutReady cycle.
- Throughput: at most one op per 2 cycles for single-cycle ops.
- InValid while busy: requests are not queued. The requester holds InValid until InReady.

## Test plan
- Reset and single-cycle op (WIDTH=32): assert Reset_n low mid-cycle → outputs reach reset values with no clock edge. Then issue add A=0xFFFFFFFF, B=1 with OutReady=1 → one cycle later OutValid=1, ALUResult=0, Zero=1, Hi=0.
- Compare and arithmetic shift (A=0xFFFFFFFE, B=0x00000001):
  - sltu (0111) → 0.
  - slt (1001) → 1.
  - sra (1010) with B=0x21 (shift amount 1) → 0xFFFFFFFF.
  - srl (0101), same B → 0x7FFFFFFF.
- Multiply: mul A=0xFFFFFFFF, B=0xFFFFFFFF → OutValid exactly 33 cycles after accept; Hi=0xFFFFFFFE, ALUResult=0x00000001; InReady low throughout.
- Divide and divide-by-zero:
  - divu A=100, B=7 → 33 cycles, ALUResult=14, Hi=2.
  - divu A=5, B=0 → 1 cycle, ALUResult=0xFFFFFFFF, Hi=5.
- Backpressure: hold OutReady=0 for 10 cycles after a result → OutValid and outputs stay stable and InReady stays 0. Raising OutReady → IDLE next edge; a new InValid is accepted one cycle later.
- Reset mid-multiply: assert Reset_n low at iteration 10 of a mul → OutValid never asserts for it. After release, an add A=2, B=3 returns 5 with 1-cycle latency. Repeat at WIDTH=8 with mul 0xFF×0xFF → Hi=0xFE, ALUResult=0x01 after 9 cycles.
